// File: rtl/game_pkg.sv
// Shared types and defaults for the rhythm-game sequencer, datapath and drawer.
package game_pkg;

  localparam int unsigned DEFAULT_NUM_LANES = 4;
  localparam int unsigned DEFAULT_FRAME_W   = 16;
  localparam int unsigned STATE_W           = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE        = 4'd0,
    S_INIT        = 4'd1,
    S_LOAD        = 4'd2,
    S_ERASE       = 4'd3,
    S_BOARD       = 4'd4,
    S_NOTES       = 4'd5,
    S_CHECK       = 4'd6,
    S_PLAYER      = 4'd7,
    S_PLAYER_WAIT = 4'd8,
    S_PAUSED      = 4'd9,
    S_GAME_OVER   = 4'd10
  } game_state_e;

  // True in the states that write to the frame buffer.
  function automatic logic is_draw_state(game_state_e s);
    return (s == S_ERASE) || (s == S_BOARD) || (s == S_NOTES);
  endfunction

endpackage

// File: rtl/game_sequencer.sv
// Frame sequencer: init, load, erase, board/lane draws, hit check, player phase,
// with pause, game-over and a completed-frame counter.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEFAULT_NUM_LANES,
  parameter int unsigned LANE_W    = $clog2(NUM_LANES),
  parameter int unsigned FRAME_W   = DEFAULT_FRAME_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 go,
  input  logic                 pause,
  input  logic                 song_end,
  input  logic                 draw_done,
  output logic                 initialize,
  output logic                 ld_notes,
  output logic                 erase_notes,
  output logic                 draw_board,
  output logic [NUM_LANES-1:0] draw_notes,
  output logic [LANE_W-1:0]    lane_idx,
  output logic                 check_notes,
  output logic                 playerEN,
  output logic                 plot,
  output logic                 paused,
  output logic                 game_over,
  output logic [FRAME_W-1:0]   frame_count
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  game_state_e          state;
  game_state_e          state_next;
  logic [LANE_W-1:0]    lane;
  logic [LANE_W-1:0]    lane_next;
  logic [FRAME_W-1:0]   frame_next;

  // State, lane and frame registers; reset abandons any draw in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      lane        <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      lane        <= lane_next;
      frame_count <= frame_next;
    end
  end

  // Next-state, lane advance and frame count update.
  always_comb begin
    state_next = state;
    lane_next  = lane;
    frame_next = frame_count;
    case (state)
      S_IDLE:        if (start) state_next = S_INIT;
      S_INIT:        state_next = S_LOAD;
      S_LOAD:        state_next = S_ERASE;
      S_ERASE:       if (draw_done) state_next = S_BOARD;
      S_BOARD: begin
        if (draw_done) begin
          state_next = S_NOTES;
          lane_next  = '0;
        end
      end
      S_NOTES: begin
        if (draw_done) begin
          if (lane == LAST_LANE) begin
            state_next = S_CHECK;
            lane_next  = '0;
          end else begin
            lane_next = lane + LANE_W'(1);
          end
        end
      end
      S_CHECK: begin
        frame_next = frame_count + FRAME_W'(1);
        state_next = song_end ? S_GAME_OVER : S_PLAYER;
      end
      // pause wins over go so a simultaneous press never starts a frame
      S_PLAYER: begin
        if (pause)   state_next = S_PAUSED;
        else if (go) state_next = S_PLAYER_WAIT;
      end
      // one frame per press: go must drop before the next frame starts
      S_PLAYER_WAIT: if (!go)    state_next = S_LOAD;
      S_PAUSED:      if (!pause) state_next = S_PLAYER;
      S_GAME_OVER:   if (start)  state_next = S_INIT;
      default: begin
        state_next = S_IDLE;
        lane_next  = '0;
      end
    endcase
    // entering INIT starts a fresh song, so the counters read zero from INIT on
    if (state_next == S_INIT) begin
      frame_next = '0;
      lane_next  = '0;
    end
  end

  // Moore output decode from state and lane.
  always_comb begin
    initialize  = 1'b0;
    ld_notes    = 1'b0;
    erase_notes = 1'b0;
    draw_board  = 1'b0;
    draw_notes  = '0;
    lane_idx    = '0;
    check_notes = 1'b0;
    playerEN    = 1'b0;
    paused      = 1'b0;
    game_over   = 1'b0;
    plot        = is_draw_state(state);
    case (state)
      S_INIT:        initialize  = 1'b1;
      S_LOAD:        ld_notes    = 1'b1;
      S_ERASE:       erase_notes = 1'b1;
      S_BOARD:       draw_board  = 1'b1;
      S_NOTES: begin
        draw_notes = NUM_LANES'(1) << lane;
        lane_idx   = lane;
      end
      S_CHECK:       check_notes = 1'b1;
      S_PLAYER:      playerEN    = 1'b1;
      S_PLAYER_WAIT: playerEN    = 1'b1;
      S_PAUSED:      paused      = 1'b1;
      S_GAME_OVER:   game_over   = 1'b1;
      default:       plot        = 1'b0;
    endcase
  end

endmodule
